tdc_run_ctrl: RTL and testbench
===============================

Name: tdc_run_ctrl

Overview:
Measurement sequencer for one TDC channel. It arms the TDC for a programmed number of measurements, resets the TDC between shots, and applies a per-shot timeout. Each finished result goes into a result FIFO that a readout consumer (UART or host bridge) drains through a valid/ready handshake. It sits between the TDC core (enable, iRst, done, oTDC) and the readout logic, all on the TDC system clock.

Parameters:
DW, 24, width of a TDC result word; must match the TDC output width
CNT_W, 16, width of the measurement-count input and the internal shot counter
RST_CYC, 4, cycles the TDC reset is held between shots (>=1)
TIMEOUT, 1024, cycles allowed in ARM before a shot is abandoned (>=2)
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW

Ports:
clk  input  1  system clock, same as TDC clk0
iRst  input  1  asynchronous active-high reset
iStart  input  1  one-cycle start-run pulse; honoured only in IDLE
iAbort  input  1  abort the run; returns to IDLE next cycle
iNumMeas  input  CNT_W  shots per run, sampled on an accepted iStart
oTdcEnable  output  1  drives TDC enable
oTdcRst  output  1  drives TDC iRst
iTdcDone  input  1  TDC done pulse
iTdcData  input  DW  TDC result, valid when iTdcDone=1
oData  output  DW  FIFO head word
oValid  output  1  FIFO not empty
iReady  input  1  consumer accepts oData
oLevel  output  FIFO_AW+1  FIFO occupancy
oBusy  output  1  state != IDLE
oRunDone  output  1  one-cycle pulse at end of run
oOverflow  output  1  sticky: a result was dropped because the FIFO was full
oTimeouts  output  8  saturating count of timed-out shots

Behaviour:
- Reset (async): state=IDLE; oTdcEnable=0; oTdcRst=1 while iRst is high, then 0 in IDLE. oValid=0, oLevel=0, oData=0, oBusy=0, oRunDone=0, oOverflow=0, oTimeouts=0. FIFO pointers are 0.
- All outputs are registered except oValid, oData and oLevel, which decode combinationally from FIFO pointers and memory.
- IDLE: iStart=1 loads shots_left=iNumMeas, clears oOverflow and oTimeouts, then goes to CLR. If iNumMeas==0 it goes to FIN instead. iStart outside IDLE is ignored.
- CLR: oTdcRst=1, oTdcEnable=0. Stays RST_CYC cycles (rst counter), then goes to ARM with the timeout timer cleared.
- ARM: oTdcEnable=1, oTdcRst=0, timer increments each cycle.
  - iTdcDone=1: push iTdcData, or set oOverflow and drop the word if the FIFO is full and no pop happens that cycle. Then shots_left-1; go to FIN if shots_left was 1, else CLR.
  - timer==TIMEOUT-1 without done: oTimeouts+1 (saturates at 255), no push. shots_left-1 and branch exactly as on done.
  - done and timeout in the same cycle: done wins and the timeout is not counted.
  - iTdcDone outside ARM is ignored and never pushes.
- FIN: oRunDone=1 for exactly one cycle, oTdcEnable=0, then IDLE.
- iAbort (any non-IDLE state, priority over all transitions): next state IDLE, oTdcEnable=0. No oRunDone. FIFO contents and flags are kept. A done arriving in the abort cycle is discarded.
- FIFO:
  - First-word fall-through; depth 2^FIFO_AW.
  - Pop when oValid&&iReady.
  - Push and pop in the same cycle is legal at any level, including full (accepted, level unchanged) and empty (not allowed: the push lands first; the pop is qualified by oValid).
  - Pointers are FIFO_AW+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
- Shot latency: from entering CLR to the earliest possible push is RST_CYC+1 cycles. The push is visible on oValid the cycle after iTdcDone.
- Width rules: shots_left is CNT_W unsigned; the timer is clog2(TIMEOUT) bits.

Test Plan:
- iNumMeas=3, TDC model returns done 20 cycles after enable with data 0x000101/0x000202/0x000303, iReady=1 → 3 words out in order, oRunDone pulse once, oTimeouts=0, oBusy low after FIN.
- TIMEOUT=64, iNumMeas=2, TDC never done → 2 CLR/ARM cycles of 64 ARM cycles each, oTimeouts=2, oValid stays 0, oRunDone pulses.
- FIFO_AW=3, iNumMeas=10, iReady=0 → oLevel=8, oOverflow=1, oData=first word. Raising iReady then drains exactly 8 words in order.
- iTdcDone asserted on the same cycle timer==TIMEOUT-1 → word pushed, oTimeouts unchanged.
- iAbort during ARM of shot 2 of 5 → IDLE next cycle, oTdcEnable=0, no oRunDone, FIFO holds 1 word. A new iStart with iNumMeas=1 runs normally and clears the flags.
- iStart with iNumMeas=0 → oRunDone pulse 2 cycles later, oTdcEnable never asserted. iRst asserted mid-ARM → all outputs go to reset values immediately.

Source files
------------

// File: rtl/tdc_run_ctrl.sv
// Measurement sequencer for one TDC channel: arms, resets and times out shots, queues results for readout.
// Latency: earliest push RST_CYC+1 cycles after a shot enters CLR; a pushed word shows on oValid the next cycle.
// Backpressure: oValid/iReady drain of a fall-through FIFO; a result arriving while full with no pop is dropped and flagged.
module tdc_run_ctrl #(
    parameter int DW      = 24,
    parameter int CNT_W   = 16,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 1024,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [CNT_W-1:0]   iNumMeas,
    output logic               oTdcEnable,
    output logic               oTdcRst,
    input  logic               iTdcDone,
    input  logic [DW-1:0]      iTdcData,
    output logic [DW-1:0]      oData,
    output logic               oValid,
    input  logic               iReady,
    output logic [FIFO_AW:0]   oLevel,
    output logic               oBusy,
    output logic               oRunDone,
    output logic               oOverflow,
    output logic [7:0]         oTimeouts
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]    RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [FIFO_AW:0]   PTR_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_ARM  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_shots_left;
    logic [TMR_W-1:0]   r_timer;
    logic [RC_W-1:0]    r_rst_cnt;
    logic               r_tdc_en;
    logic               r_tdc_rst;
    logic               r_busy;
    logic               r_run_done;
    logic               r_overflow;
    logic [7:0]         r_timeouts;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_done_arm;
    logic               w_timeout;
    logic               w_push;
    logic               w_drop;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_pop      = !w_empty && iReady;

    // A done in the abort cycle is discarded; done beats a coincident timeout.
    assign w_done_arm = (r_state == S_ARM) && iTdcDone && !iAbort;
    assign w_timeout  = (r_state == S_ARM) && !iTdcDone && !iAbort && (r_timer == TMR_LAST);
    assign w_push     = w_done_arm && (!w_full || w_pop);
    assign w_drop     = w_done_arm && w_full && !w_pop;

    assign oValid     = !w_empty;
    assign oLevel     = r_wr_ptr - r_rd_ptr;
    // Gate the head word so an empty FIFO never exposes stale or unreset memory.
    assign oData      = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];

    assign oTdcEnable = r_tdc_en;
    assign oTdcRst    = r_tdc_rst;
    assign oBusy      = r_busy;
    assign oRunDone   = r_run_done;
    assign oOverflow  = r_overflow;
    assign oTimeouts  = r_timeouts;

    // Run sequencer: state, shot/reset/timeout counters, registered TDC controls and run flags.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            r_state      <= S_IDLE;
            r_shots_left <= '0;
            r_timer      <= '0;
            r_rst_cnt    <= '0;
            r_tdc_en     <= 1'b0;
            r_tdc_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_run_done   <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeouts   <= 8'd0;
        end else begin
            r_run_done <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_timeout && (r_timeouts != 8'hFF)) begin
                r_timeouts <= r_timeouts + 8'd1;
            end

            if (iAbort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_tdc_en  <= 1'b0;
                r_tdc_rst <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tdc_en  <= 1'b0;
                        r_tdc_rst <= 1'b0;
                        if (iStart) begin
                            r_shots_left <= iNumMeas;
                            r_overflow   <= 1'b0;
                            r_timeouts   <= 8'd0;
                            r_rst_cnt    <= '0;
                            r_busy       <= 1'b1;
                            if (iNumMeas == '0) begin
                                r_state <= S_FIN;
                            end else begin
                                r_state   <= S_CLR;
                                r_tdc_rst <= 1'b1;
                            end
                        end
                    end
                    S_CLR: begin
                        if (r_rst_cnt == RC_LAST) begin
                            r_state   <= S_ARM;
                            r_timer   <= '0;
                            r_tdc_rst <= 1'b0;
                            r_tdc_en  <= 1'b1;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RC_W'(1);
                        end
                    end
                    S_ARM: begin
                        r_timer <= r_timer + TMR_W'(1);
                        if (iTdcDone || (r_timer == TMR_LAST)) begin
                            r_shots_left <= r_shots_left - CNT_W'(1);
                            r_tdc_en     <= 1'b0;
                            if (r_shots_left == CNT_W'(1)) begin
                                r_state <= S_FIN;
                            end else begin
                                r_state   <= S_CLR;
                                r_rst_cnt <= '0;
                                r_tdc_rst <= 1'b1;
                            end
                        end
                    end
                    S_FIN: begin
                        r_run_done <= 1'b1;
                        r_tdc_en   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO pointers; pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= iTdcData;
        end
    end

endmodule

// File: tb/tb_tdc_run_ctrl.sv
// Bench for tdc_run_ctrl: randomized TDC responses and readout stall against a queue-based reference.
// Latency: checks run-end cycle, ARM window lengths and CLR lengths from per-shot delays.
// Backpressure: iReady randomized; reference FIFO drops words when full with no pop.
module tb_tdc_run_ctrl;

    localparam int DW      = 24;
    localparam int CNT_W   = 16;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 64;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int LW      = FIFO_AW + 1;

    logic               clk = 1'b0;
    logic               iRst;
    logic               iStart;
    logic               iAbort;
    logic [CNT_W-1:0]   iNumMeas;
    logic               oTdcEnable;
    logic               oTdcRst;
    logic               iTdcDone;
    logic [DW-1:0]      iTdcData;
    logic [DW-1:0]      oData;
    logic               oValid;
    logic               iReady;
    logic [FIFO_AW:0]   oLevel;
    logic               oBusy;
    logic               oRunDone;
    logic               oOverflow;
    logic [7:0]         oTimeouts;

    tdc_run_ctrl #(
        .DW(DW), .CNT_W(CNT_W), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort), .iNumMeas(iNumMeas),
        .oTdcEnable(oTdcEnable), .oTdcRst(oTdcRst), .iTdcDone(iTdcDone), .iTdcData(iTdcData),
        .oData(oData), .oValid(oValid), .iReady(iReady), .oLevel(oLevel), .oBusy(oBusy),
        .oRunDone(oRunDone), .oOverflow(oOverflow), .oTimeouts(oTimeouts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference FIFO contents, words seen leaving the DUT, and words the reference says should leave.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] obs_q[$];
    logic [DW-1:0] ref_q[$];
    int            dly_q[$];
    logic [DW-1:0] dat_q[$];
    int            win_len[$];
    int            gap_len[$];
    int            done_pulses, done_cycle, en_seen, vmis, lmis, both_hi, run_to;
    bit            m_ovf;
    logic          ab_en, ab_busy;
    logic          rs_en, rs_rst, rs_valid, rs_busy, rs_done, rs_ovf;
    logic [FIFO_AW:0] rs_level;
    logic [DW-1:0] rs_data;
    logic [7:0]    rs_to;

    // Expected cycles from the start pulse to the sample showing oRunDone.
    function automatic int exp_cycles(int n);
        int s = 2;
        for (int k = 0; k < n; k++)
            s += RST_CYC + ((dly_q[k] < TIMEOUT) ? dly_q[k] : TIMEOUT - 1) + 1;
        return s;
    endfunction

    function automatic int exp_tos(int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (dly_q[k] >= TIMEOUT) c++;
        return (c > 255) ? 255 : c;
    endfunction

    function automatic int exp_words(int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (dly_q[k] < TIMEOUT) c++;
        return c;
    endfunction

    // One cycle of the reference FIFO: observe, pop, then push.
    task automatic model_step(input bit rdy, input bit psh, input logic [DW-1:0] d);
        if (oValid !== (mq.size() > 0)) vmis++;
        if (oLevel !== LW'(mq.size())) lmis++;
        if (oValid && rdy) obs_q.push_back(oData);
        if (rdy && mq.size() > 0) ref_q.push_back(mq.pop_front());
        if (psh) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end
    endtask

    // Start a run and act as the TDC: answer shot k after dly_q[k] enabled cycles.
    // kind: 0 plain, 1 abort during shot ev_shot, 2 async reset during shot ev_shot.
    task automatic run(input int n, input int pct, input int kind, input int ev_shot, input int budget);
        int shot = 0, arm_cnt = 0, cur_win = 0, cur_gap = 0, ev_i = -1;
        bit prev_en = 0, prev_rst = 0, rdy, psh;
        win_len.delete(); gap_len.delete();
        done_pulses = 0; done_cycle = -1; en_seen = 0; vmis = 0; lmis = 0;
        both_hi = 0; run_to = 0; m_ovf = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (i > 0) begin
                if (oRunDone) begin
                    done_pulses++;
                    if (done_cycle < 0) done_cycle = i;
                end
                if (oTdcEnable) en_seen++;
                if (oTdcEnable && oTdcRst) both_hi++;
                if (prev_en && !oTdcEnable) begin
                    win_len.push_back(cur_win); shot++; arm_cnt = 0; cur_win = 0;
                end
                if (prev_rst && !oTdcRst) begin
                    gap_len.push_back(cur_gap); cur_gap = 0;
                end
                if (oTdcRst) cur_gap++;
                if (oTdcEnable) cur_win++;
                prev_en = oTdcEnable; prev_rst = oTdcRst;
            end
            if (kind == 1 && ev_i >= 0 && i == ev_i + 1) begin
                ab_en = oTdcEnable; ab_busy = oBusy;
            end
            if (kind == 1 && ev_i >= 0 && i == ev_i + 4) break;
            if (kind == 0 && done_pulses > 0) break;
            if (i == budget) begin
                run_to = 1;
                break;
            end
            iStart   = (i == 0);
            iNumMeas = CNT_W'(n);
            iAbort   = 1'b0;
            iTdcDone = 1'b0;
            iTdcData = '0;
            rdy      = ($urandom_range(99) < pct);
            iReady   = rdy;
            psh      = 1'b0;
            if (oTdcEnable && ev_i < 0 && shot < dly_q.size()) begin
                if (kind != 0 && shot == ev_shot && arm_cnt == 5) begin
                    if (kind == 1) begin
                        iAbort = 1'b1; iTdcDone = 1'b1; iTdcData = 24'hDEAD01; ev_i = i;
                    end else begin
                        iRst = 1'b1;
                        #1;
                        rs_en = oTdcEnable; rs_rst = oTdcRst; rs_valid = oValid; rs_level = oLevel;
                        rs_data = oData; rs_busy = oBusy; rs_done = oRunDone; rs_ovf = oOverflow;
                        rs_to = oTimeouts; ev_i = i;
                    end
                end else if (arm_cnt == dly_q[shot]) begin
                    iTdcDone = 1'b1; iTdcData = dat_q[shot]; psh = 1'b1;
                end
                arm_cnt++;
            end
            if (kind == 2 && ev_i >= 0) break;
            model_step(rdy, psh, iTdcData);
            @(negedge clk);
        end
        iStart = 1'b0; iAbort = 1'b0; iTdcDone = 1'b0; iReady = 1'b0;
    endtask

    task automatic drain(input int cycles, input int pct);
        bit rdy;
        for (int i = 0; i < cycles; i++) begin
            rdy = ($urandom_range(99) < pct);
            iReady = rdy; iTdcDone = 1'b0; iStart = 1'b0;
            model_step(rdy, 1'b0, '0);
            @(negedge clk);
        end
        iReady = 1'b0;
    endtask

    task automatic test_reset;
        iRst = 1'b1; iStart = 0; iAbort = 0; iNumMeas = '0; iTdcDone = 0; iTdcData = '0; iReady = 0;
        repeat (2) @(negedge clk);
        total++; if (oTdcRst !== 1'b1) begin bad++; $display("FAIL reset_tdcrst got=%b want=1", oTdcRst); end
        total++; if (oTdcEnable !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", oTdcEnable); end
        total++; if ({oValid, oBusy, oRunDone, oOverflow} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {oValid, oBusy, oRunDone, oOverflow}); end
        total++; if (oLevel !== '0 || oData !== '0 || oTimeouts !== 8'd0) begin bad++; $display("FAIL reset_vals got lvl=%0d data=%0h to=%0d want 0", oLevel, oData, oTimeouts); end
        iRst = 1'b0;
        @(negedge clk);
        total++; if (oTdcRst !== 1'b0) begin bad++; $display("FAIL idle_tdcrst got=%b want=0", oTdcRst); end
    endtask

    task automatic test_basic;
        dly_q = '{20, 20, 20};
        dat_q = '{24'h000101, 24'h000202, 24'h000303};
        obs_q.delete(); ref_q.delete();
        run(3, 100, 0, 0, 2000);
        drain(4, 100);
        total++; if (run_to != 0 || done_pulses != 1) begin bad++; $display("FAIL basic_rundone got=%0d want=1", done_pulses); end
        total++; if (done_cycle != exp_cycles(3)) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", done_cycle, exp_cycles(3)); end
        total++; if (obs_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d want=3", obs_q.size()); end
        for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
            total++; if (obs_q[k] !== dat_q[k]) begin bad++; $display("FAIL basic_word%0d got=%0h want=%0h", k, obs_q[k], dat_q[k]); end
        end
        total++; if (oTimeouts !== 8'd0 || oBusy !== 1'b0) begin bad++; $display("FAIL basic_end got to=%0d busy=%b want 0/0", oTimeouts, oBusy); end
        total++; if (gap_len.size() != 3) begin bad++; $display("FAIL basic_clrcount got=%0d want=3", gap_len.size()); end
        foreach (gap_len[k]) begin
            total++; if (gap_len[k] != RST_CYC) begin bad++; $display("FAIL basic_clrlen got=%0d want=%0d", gap_len[k], RST_CYC); end
        end
        total++; if (vmis != 0 || lmis != 0 || both_hi != 0) begin bad++; $display("FAIL basic_fifo got vmis=%0d lmis=%0d both=%0d want 0", vmis, lmis, both_hi); end
    endtask

    task automatic test_timeout;
        dly_q = '{TIMEOUT + 100, TIMEOUT + 100};
        dat_q = '{24'h0A0A0A, 24'h0B0B0B};
        obs_q.delete(); ref_q.delete();
        run(2, 100, 0, 0, 2000);
        total++; if (done_pulses != 1) begin bad++; $display("FAIL to_rundone got=%0d want=1", done_pulses); end
        total++; if (oTimeouts !== 8'd2) begin bad++; $display("FAIL to_count got=%0d want=2", oTimeouts); end
        total++; if (win_len.size() != 2) begin bad++; $display("FAIL to_windows got=%0d want=2", win_len.size()); end
        foreach (win_len[k]) begin
            total++; if (win_len[k] != TIMEOUT) begin bad++; $display("FAIL to_armlen got=%0d want=%0d", win_len[k], TIMEOUT); end
        end
        total++; if (vmis != 0 || obs_q.size() != 0) begin bad++; $display("FAIL to_novalid got vmis=%0d words=%0d want 0", vmis, obs_q.size()); end
        total++; if (done_cycle != exp_cycles(2)) begin bad++; $display("FAIL to_latency got=%0d want=%0d", done_cycle, exp_cycles(2)); end
    endtask

    task automatic test_tie;
        dly_q = '{TIMEOUT - 1, TIMEOUT, 7};
        dat_q = '{24'($urandom), 24'($urandom), 24'($urandom)};
        obs_q.delete(); ref_q.delete();
        run(3, 100, 0, 0, 2000);
        drain(4, 100);
        total++; if (oTimeouts !== 8'd1) begin bad++; $display("FAIL tie_timeouts got=%0d want=1", oTimeouts); end
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL tie_count got=%0d want=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[0] !== dat_q[0] || obs_q[1] !== dat_q[2]) begin bad++; $display("FAIL tie_words got=%0h,%0h want=%0h,%0h", obs_q[0], obs_q[1], dat_q[0], dat_q[2]); end
        end
        total++; if (win_len.size() < 1 || win_len[0] != TIMEOUT) begin bad++; $display("FAIL tie_armlen got=%0d want=%0d", (win_len.size() > 0) ? win_len[0] : -1, TIMEOUT); end
    endtask

    task automatic test_random;
        int n, sel;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            dly_q.delete(); dat_q.delete(); obs_q.delete(); ref_q.delete();
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 3);
                dly_q.push_back(sel == 0 ? TIMEOUT + 5 : (sel == 1 ? TIMEOUT - 1 : $urandom_range(0, 40)));
                dat_q.push_back(24'($urandom));
            end
            run(n, 60, 0, 0, 3000);
            drain(20, 100);
            total++; if (done_pulses != 1 || done_cycle != exp_cycles(n)) begin bad++; $display("FAIL rnd%0d_end got=%0d@%0d want=1@%0d", r, done_pulses, done_cycle, exp_cycles(n)); end
            total++; if (oTimeouts !== 8'(exp_tos(n))) begin bad++; $display("FAIL rnd%0d_timeouts got=%0d want=%0d", r, oTimeouts, exp_tos(n)); end
            total++; if (obs_q.size() != exp_words(n) || ref_q.size() != exp_words(n)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, obs_q.size(), exp_words(n)); end
            for (int k = 0; k < obs_q.size() && k < ref_q.size(); k++) begin
                total++; if (obs_q[k] !== ref_q[k]) begin bad++; $display("FAIL rnd%0d_word%0d got=%0h want=%0h", r, k, obs_q[k], ref_q[k]); end
            end
            total++; if (win_len.size() != n) begin bad++; $display("FAIL rnd%0d_windows got=%0d want=%0d", r, win_len.size(), n); end
            for (int k = 0; k < win_len.size() && k < n; k++) begin
                total++; if (win_len[k] != ((dly_q[k] < TIMEOUT) ? dly_q[k] + 1 : TIMEOUT)) begin bad++; $display("FAIL rnd%0d_armlen%0d got=%0d want=%0d", r, k, win_len[k], (dly_q[k] < TIMEOUT) ? dly_q[k] + 1 : TIMEOUT); end
            end
            total++; if (vmis != 0 || lmis != 0 || both_hi != 0 || oOverflow !== 1'b0) begin bad++; $display("FAIL rnd%0d_fifo got vmis=%0d lmis=%0d both=%0d ovf=%b want 0", r, vmis, lmis, both_hi, oOverflow); end
        end
    endtask

    task automatic test_overflow;
        logic [DW-1:0] first[$];
        dly_q.delete(); dat_q.delete(); obs_q.delete(); ref_q.delete();
        for (int k = 0; k < 10; k++) begin
            dly_q.push_back($urandom_range(0, 30));
            dat_q.push_back(24'($urandom));
        end
        first = dat_q;
        run(10, 0, 0, 0, 3000);
        total++; if (oLevel !== LW'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d want=%0d", oLevel, DEPTH); end
        total++; if (oOverflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", oOverflow); end
        total++; if (oData !== first[0]) begin bad++; $display("FAIL ovf_head got=%0h want=%0h", oData, first[0]); end
        // Second run starts against a full FIFO with a slow reader: push and pop while full.
        dly_q = '{3, 3, 3, 3};
        dat_q.delete();
        for (int k = 0; k < 4; k++) dat_q.push_back(24'($urandom));
        run(4, 40, 0, 0, 2000);
        total++; if (oOverflow !== m_ovf) begin bad++; $display("FAIL ovf_run2_flag got=%b want=%b", oOverflow, m_ovf); end
        drain(20, 100);
        total++; if (obs_q.size() != ref_q.size() || obs_q.size() < DEPTH) begin bad++; $display("FAIL ovf_drain_count got=%0d want=%0d", obs_q.size(), ref_q.size()); end
        for (int k = 0; k < DEPTH && k < obs_q.size(); k++) begin
            total++; if (obs_q[k] !== first[k]) begin bad++; $display("FAIL ovf_word%0d got=%0h want=%0h", k, obs_q[k], first[k]); end
        end
        for (int k = DEPTH; k < obs_q.size() && k < ref_q.size(); k++) begin
            total++; if (obs_q[k] !== ref_q[k]) begin bad++; $display("FAIL ovf_run2_word%0d got=%0h want=%0h", k, obs_q[k], ref_q[k]); end
        end
        total++; if (vmis != 0 || lmis != 0) begin bad++; $display("FAIL ovf_model got vmis=%0d lmis=%0d want 0", vmis, lmis); end
    endtask

    task automatic test_abort;
        logic [DW-1:0] kept;
        dly_q = '{TIMEOUT + 1, 10, 10, 10, 10};
        dat_q.delete();
        for (int k = 0; k < 5; k++) dat_q.push_back(24'($urandom));
        kept = dat_q[1];
        obs_q.delete(); ref_q.delete();
        run(5, 0, 1, 2, 3000);
        total++; if (ab_en !== 1'b0 || ab_busy !== 1'b0) begin bad++; $display("FAIL abort_idle got en=%b busy=%b want 0/0", ab_en, ab_busy); end
        total++; if (done_pulses != 0) begin bad++; $display("FAIL abort_norundone got=%0d want=0", done_pulses); end
        total++; if (oLevel !== LW'(1)) begin bad++; $display("FAIL abort_level got=%0d want=1", oLevel); end
        total++; if (oTimeouts !== 8'd1) begin bad++; $display("FAIL abort_keepto got=%0d want=1", oTimeouts); end
        dly_q = '{10};
        dat_q = '{24'h5A5A5A};
        run(1, 100, 0, 0, 2000);
        drain(4, 100);
        total++; if (done_pulses != 1 || oTimeouts !== 8'd0) begin bad++; $display("FAIL abort_rerun got pulses=%0d to=%0d want 1/0", done_pulses, oTimeouts); end
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL abort_words got=%0d want=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[0] !== kept || obs_q[1] !== 24'h5A5A5A) begin bad++; $display("FAIL abort_data got=%0h,%0h want=%0h,5a5a5a", obs_q[0], obs_q[1], kept); end
        end
    endtask

    task automatic test_zero_meas;
        dly_q.delete(); dat_q.delete(); obs_q.delete(); ref_q.delete();
        run(0, 100, 0, 0, 50);
        total++; if (done_pulses != 1 || done_cycle != 2) begin bad++; $display("FAIL zero_rundone got=%0d@%0d want=1@2", done_pulses, done_cycle); end
        total++; if (en_seen != 0 || gap_len.size() != 0) begin bad++; $display("FAIL zero_noarm got en=%0d clr=%0d want 0/0", en_seen, gap_len.size()); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", oBusy); end
    endtask

    task automatic test_reset_mid;
        dly_q = '{TIMEOUT + 1, 5, 5, TIMEOUT + 1};
        dat_q = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        obs_q.delete(); ref_q.delete();
        run(4, 0, 2, 3, 3000);
        total++; if (rs_en !== 1'b0 || rs_rst !== 1'b1) begin bad++; $display("FAIL rstmid_tdc got en=%b rst=%b want 0/1", rs_en, rs_rst); end
        total++; if (rs_valid !== 1'b0 || rs_level !== '0 || rs_data !== '0) begin bad++; $display("FAIL rstmid_fifo got v=%b lvl=%0d d=%0h want 0", rs_valid, rs_level, rs_data); end
        total++; if ({rs_busy, rs_done, rs_ovf} !== 3'b0 || rs_to !== 8'd0) begin bad++; $display("FAIL rstmid_flags got=%b to=%0d want 0", {rs_busy, rs_done, rs_ovf}, rs_to); end
        mq.delete();
        @(negedge clk);
        iRst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        iRst = 1'b1;
        test_reset();
        test_basic();
        test_timeout();
        test_tie();
        test_random();
        test_overflow();
        test_abort();
        test_zero_meas();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
